// File: rtl/display_pkg.sv
// Shared display definitions: seven-segment patterns {dp,g,f,e,d,c,b,a},
// the serializer state type and a small bit-reversal helper.
package display_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      r[k] = v[7-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble + decimal point to seven-segment pattern.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd15:   seg = SEG_BLANK;
      default: seg = SEG_DASH;
    endcase
    seg[7] = seg[7] | dp;
  end

endmodule

// File: rtl/seg_serializer.sv
// Serial driver for chained 74HC595-style seven-segment displays:
// capture a BCD frame, encode it, shift it out and pulse the latch.
module seg_serializer
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 2,
  parameter int MSB_FIRST      = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic                    ser_data,
  output logic                    ser_clk,
  output logic                    ser_latch,
  output logic                    sending_data,
  output logic                    done
);

  localparam int NBITS = NUM_DIGITS * 8;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(NBITS);

  state_t                  state, nstate;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [NBITS-1:0]        shreg;
  logic [4*NUM_DIGITS-1:0] cap_bcd;
  logic [NUM_DIGITS-1:0]   cap_dp;
  logic                    cap_blz;

  logic                    div_wrap;
  logic                    bit_last;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [3:0]              enc_nib [NUM_DIGITS];
  logic [7:0]              seg_raw [NUM_DIGITS];
  logic [NBITS-1:0]        frame;

  assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_cnt == BIT_W'(NBITS - 1));

  // Blanking runs from the top digit down and stops at the first nonzero one.
  always_comb begin
    logic run;
    int unsigned i;
    lead_zero = '0;
    run       = cap_blz;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      i            = NUM_DIGITS - 1 - k;
      run          = run && (cap_bcd[4*i +: 4] == 4'd0);
      lead_zero[i] = run;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    // A blanked digit is fed as the blank code so its dp still shows.
    assign enc_nib[g] = lead_zero[g] ? 4'hF : cap_bcd[4*g +: 4];
    bcd_to_seg u_enc (
      .bcd (enc_nib[g]),
      .dp  (cap_dp[g]),
      .seg (seg_raw[g])
    );
  end

  always_comb begin
    logic [7:0] b8;
    frame = '0;
    for (int unsigned g = 0; g < NUM_DIGITS; g++) begin
      b8 = seg_raw[g];
      if (MSB_FIRST == 0) b8 = rev8(b8);
      if (SEG_ACTIVE_LOW != 0) b8 = ~b8;
      frame[8*g +: 8] = b8;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else if (enable) begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = LOAD;
      LOAD:    nstate = SHIFT;
      SHIFT:   if (div_wrap && ser_clk && bit_last) nstate = LATCH;
      LATCH:   if (div_wrap) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      cap_bcd      <= '0;
      cap_dp       <= '0;
      cap_blz      <= 1'b0;
      ser_data     <= 1'b0;
      ser_clk      <= 1'b0;
      ser_latch    <= 1'b0;
      sending_data <= 1'b0;
      done         <= 1'b0;
    end else if (enable) begin
      done         <= 1'b0;
      sending_data <= (nstate != IDLE);
      unique case (state)
        IDLE: begin
          if (start) begin
            cap_bcd <= bcd_in;
            cap_dp  <= dp_in;
            cap_blz <= blank_lz;
          end
        end
        LOAD: begin
          shreg    <= {frame[NBITS-2:0], 1'b0};
          ser_data <= frame[NBITS-1];
          ser_clk  <= 1'b0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt <= '0;
            if (!ser_clk) begin
              ser_clk <= 1'b1;
            end else begin
              ser_clk <= 1'b0;
              if (bit_last) begin
                ser_data  <= 1'b0;
                ser_latch <= 1'b1;
              end else begin
                ser_data <= shreg[NBITS-1];
                shreg    <= {shreg[NBITS-2:0], 1'b0};
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (div_wrap) begin
            div_cnt   <= '0;
            ser_latch <= 1'b0;
            done      <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serializer.sv
// Bench for seg_serializer: two parameterisations, bitstreams captured on rising
// ser_clk and compared with a table-driven frame model.
module tb_seg_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;

  logic a_sd, a_sc, a_sl, a_sb, a_dn;
  logic b_sd, b_sc, b_sl, b_sb, b_dn;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_serializer #(.NUM_DIGITS(4), .CLK_DIV(2), .MSB_FIRST(1), .SEG_ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .start(start_a), .bcd_in(bcd_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .ser_data(a_sd), .ser_clk(a_sc),
    .ser_latch(a_sl), .sending_data(a_sb), .done(a_dn)
  );

  seg_serializer #(.NUM_DIGITS(4), .CLK_DIV(1), .MSB_FIRST(0), .SEG_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .start(start_b), .bcd_in(bcd_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .ser_data(b_sd), .ser_clk(b_sc),
    .ser_latch(b_sl), .sending_data(b_sb), .done(b_dn)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs(input int sel);
    return (sel == 0) ? {a_sd, a_sc, a_sl, a_sb, a_dn} : {b_sd, b_sc, b_sl, b_sb, b_dn};
  endfunction

  // Monitor: bits taken on rising ser_clk, latch/done/data-in-latch tallies.
  bit rx0[$];
  bit rx1[$];
  logic [1:0] prev_sc = '0;
  int latch_cyc[2] = '{0, 0};
  int latch_bad[2] = '{0, 0};
  int done_cnt[2]  = '{0, 0};

  always @(negedge clk) begin
    logic [1:0] sd, sc, sl, dn;
    sd = {b_sd, a_sd}; sc = {b_sc, a_sc}; sl = {b_sl, a_sl}; dn = {b_dn, a_dn};
    for (int s = 0; s < 2; s++) begin
      if (sc[s] && !prev_sc[s]) begin
        if (s == 0) rx0.push_back(sd[s]);
        else        rx1.push_back(sd[s]);
      end
      if (sl[s]) begin
        latch_cyc[s]++;
        if (sd[s]) latch_bad[s]++;
      end
      if (dn[s]) done_cnt[s]++;
    end
    prev_sc = sc;
  end

  // Reference frame: first transmitted bit lands in bit 31.
  function automatic logic [31:0] model(input logic [15:0] bcd, input logic [3:0] dp,
                                        input logic blz, input bit msb, input bit pol);
    logic [7:0] tab [16];
    logic [31:0] r;
    logic [7:0] s;
    bit leading;
    tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
            8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00};
    r = '0;
    leading = blz;
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] d;
      d = bcd[4*i +: 4];
      if (leading && d == 4'd0 && i != 0) s = 8'h00;
      else begin
        leading = 1'b0;
        s = tab[d];
      end
      if (dp[i]) s[7] = 1'b1;
      if (pol) s = ~s;
      for (int k = 0; k < 8; k++) r = {r[30:0], msb ? s[7-k] : s[k]};
    end
    return r;
  endfunction

  // Re-assemble received bits into segment words (line level), first digit in [31:24].
  function automatic logic [31:0] to_words(input logic [31:0] bits, input bit msb);
    logic [31:0] w;
    logic [7:0] c;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      c = bits[31-8*j -: 8];
      if (!msb) for (int k = 0; k < 8; k++) w[31-8*j-7+k] = c[7-k];
      else w[31-8*j -: 8] = c;
    end
    return w;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  logic [31:0] last_words;

  task automatic run_frame(input int sel, input logic [15:0] bcd, input logic [3:0] dp,
                           input logic blz, input int pause_at, input bit disturb);
    int cd, exp_len, n, base_rx, base_done, base_latch, base_bad, frozen_bad, nrx;
    bit msb, pol;
    logic [4:0] snap;
    logic [31:0] got;
    cd  = (sel == 0) ? 2 : 1;
    msb = (sel == 0);
    pol = (sel != 0);
    exp_len = 1 + 32 * 2 * cd + cd + 1 + ((pause_at > 0) ? 10 : 0);
    @(negedge clk);
    base_rx    = (sel == 0) ? rx0.size() : rx1.size();
    base_done  = done_cnt[sel];
    base_latch = latch_cyc[sel];
    base_bad   = latch_bad[sel];
    bcd_in = bcd; dp_in = dp; blank_lz = blz;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    n = 1;
    frozen_bad = 0;
    check($sformatf("busy_after_start[%0d]", sel), outs(sel) & 5'b00010, 5'b00010);
    while (!(outs(sel) & 5'b00001) && n < 4000) begin
      if (pause_at > 0 && n == pause_at) begin
        enable = 1'b0;
        snap = outs(sel);
        repeat (10) begin
          @(negedge clk);
          n++;
          if (outs(sel) !== snap) frozen_bad++;
        end
        enable = 1'b1;
      end
      if (disturb && n == 40) begin
        set_start(sel, 1'b1);
        bcd_in = ~bcd;
        dp_in  = ~dp;
      end
      if (disturb && n == 41) set_start(sel, 1'b0);
      @(negedge clk);
      n++;
    end
    check($sformatf("frame_len[%0d]", sel), n, exp_len);
    check($sformatf("idle_at_done[%0d]", sel), outs(sel), 5'b00001);
    if (pause_at > 0) check($sformatf("pause_frozen[%0d]", sel), frozen_bad, 0);
    repeat (3) @(negedge clk);
    nrx = ((sel == 0) ? rx0.size() : rx1.size()) - base_rx;
    check($sformatf("done_count[%0d]", sel), done_cnt[sel] - base_done, 1);
    check($sformatf("latch_cycles[%0d]", sel), latch_cyc[sel] - base_latch, cd);
    check($sformatf("latch_data_zero[%0d]", sel), latch_bad[sel] - base_bad, 0);
    check($sformatf("bit_count[%0d]", sel), nrx, 32);
    got = '0;
    for (int k = 0; k < 32 && k < nrx; k++)
      got = {got[30:0], (sel == 0) ? rx0[base_rx + k] : rx1[base_rx + k]};
    check($sformatf("bits[%0d] bcd=%h dp=%h blz=%0d", sel, bcd, dp, blz), got,
          model(bcd, dp, blz, msb, pol));
    last_words = to_words(got, msb);
  endtask

  initial begin
    int base_done, base_latch;
    repeat (3) @(negedge clk);
    check("reset_outs_a", outs(0), 5'b0);
    check("reset_outs_b", outs(1), 5'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs_a", outs(0), 5'b0);

    run_frame(0, 16'h2571, 4'b0000, 1'b0, 0, 1'b0);
    check("words_2571", last_words, 32'h5B6D0706);
    run_frame(0, 16'h0047, 4'b0010, 1'b1, 0, 1'b0);
    check("words_0047_blz", last_words, 32'h0000E607);
    run_frame(0, 16'h0000, 4'b0000, 1'b1, 0, 1'b0);
    check("words_0000_blz", last_words, 32'h0000003F);
    run_frame(1, 16'hFA09, 4'b0000, 1'b0, 0, 1'b0);
    check("words_FA09_inv_lsb", last_words, 32'hFFBFC090);

    run_frame(0, 16'h1234, 4'b0101, 1'b0, 0, 1'b1);
    run_frame(0, 16'h0908, 4'b1000, 1'b1, 25, 1'b0);
    run_frame(1, 16'h0030, 4'b0100, 1'b1, 12, 1'b1);

    // Reset in the middle of a shift: frame dropped, outputs cleared next edge.
    @(negedge clk);
    base_done = done_cnt[0];
    base_latch = latch_cyc[0];
    bcd_in = 16'h8888;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_outs_a", outs(0), 5'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (150) @(negedge clk);
    check("mid_reset_no_done", done_cnt[0] - base_done, 0);
    check("mid_reset_no_latch", latch_cyc[0] - base_latch, 0);
    run_frame(0, 16'h8888, 4'b1111, 1'b0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [15:0] b;
      for (int d = 0; d < 4; d++)
        b[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      run_frame(i % 2, b, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 30)) : 0,
                1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
